// File: rtl/zap_fetch_sequencer_pkg.sv
// Shared types and constants for the fetch-address sequencer.
package zap_fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_SLEEP = 2'd3
  } fetch_state_t;

  localparam logic [31:0] ARM_INC   = 32'd4;
  localparam logic [31:0] THUMB_INC = 32'd2;

  // Redirect sources listed from highest to lowest priority.
  typedef enum logic [1:0] {
    RDR_NONE      = 2'd0,
    RDR_WRITEBACK = 2'd1,
    RDR_ALU       = 2'd2,
    RDR_DECODE    = 2'd3
  } redirect_src_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        abort;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  function automatic redirect_src_t pick_redirect(input logic wb, input logic alu, input logic dec);
    redirect_src_t src;
    src = RDR_NONE;
    if (wb)       src = RDR_WRITEBACK;
    else if (alu) src = RDR_ALU;
    else if (dec) src = RDR_DECODE;
    return src;
  endfunction

  function automatic logic [31:0] pc_increment(input logic thumb);
    return thumb ? THUMB_INC : ARM_INC;
  endfunction

endpackage

// File: rtl/zap_sync_fifo.sv
// Small synchronous FIFO with flush; head entry is presented combinationally.
module zap_sync_fifo
  import zap_fetch_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = ENTRY_W,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // Status flags, head data and qualified push/pop strobes.
  always_comb begin
    full_o  = (count_q == CW'(DEPTH));
    empty_o = (count_q == '0);
    count_o = count_q;
    data_o  = mem_q[rd_ptr_q];
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
  end

  // Storage and pointer update; flush clears occupancy and beats push/pop.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_reset)
    !(push_i && full_o && !pop_i));

endmodule

// File: rtl/zap_fetch_sequencer.sv
// Fetch-address sequencer: issues one instruction-bus request at a time,
// buffers responses and applies prioritised redirects.
module zap_fetch_sequencer
  import zap_fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_clear_from_writeback,
  input  logic [31:0] i_pc_from_writeback,
  input  logic        i_clear_from_alu,
  input  logic [31:0] i_pc_from_alu,
  input  logic        i_clear_from_decode,
  input  logic [31:0] i_pc_from_decode,
  input  logic        i_cpsr_t,
  output logic        o_ireq,
  output logic [31:0] o_iaddr,
  input  logic        i_iack,
  input  logic        i_irsp_valid,
  input  logic [31:0] i_irsp_data,
  input  logic        i_irsp_abort,
  output logic        o_valid,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc,
  output logic        o_instr_abort
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          discard_q, discard_d;

  redirect_src_t redirect_src;
  logic          redirect;
  logic [31:0]   redirect_pc;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          slot_left;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;

  // Redirect priority mux: writeback over ALU over decode.
  always_comb begin
    redirect_src = pick_redirect(i_clear_from_writeback, i_clear_from_alu, i_clear_from_decode);
    redirect     = (redirect_src != RDR_NONE);
    unique case (redirect_src)
      RDR_WRITEBACK: redirect_pc = i_pc_from_writeback;
      RDR_ALU:       redirect_pc = i_pc_from_alu;
      RDR_DECODE:    redirect_pc = i_pc_from_decode;
      default:       redirect_pc = fetch_pc_q;
    endcase
  end

  // FIFO control: pop on consume, flush on redirect, room check after this cycle's pop.
  always_comb begin
    fifo_pop   = !fifo_empty && !i_stall;
    slot_left  = (fifo_count < CW'(FIFO_DEPTH - 1)) || fifo_pop;
    push_entry = '{instr: i_irsp_data, pc: req_pc_q, abort: i_irsp_abort};
  end

  // State register with fetch address, in-flight address and discard flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      discard_q  <= discard_d;
    end
  end

  // Next-state logic. A request accepted in a redirect cycle is still in
  // flight, so it is marked for discard instead of being forgotten.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    discard_d  = discard_q;
    fifo_push  = 1'b0;
    if (redirect) fetch_pc_d = redirect_pc;
    unique case (state_q)
      S_IDLE: begin
        if (!redirect && !fifo_full) state_d = S_REQ;
      end
      S_REQ: begin
        if (i_iack) begin
          req_pc_d = fetch_pc_q;
          state_d  = S_WAIT;
          if (redirect) discard_d  = 1'b1;
          else          fetch_pc_d = fetch_pc_q + pc_increment(i_cpsr_t);
        end else if (redirect) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (i_irsp_valid) begin
          discard_d = 1'b0;
          if (redirect || discard_q) begin
            state_d = S_IDLE;
          end else begin
            fifo_push = 1'b1;
            if (i_irsp_abort)   state_d = S_SLEEP;
            else if (slot_left) state_d = S_REQ;
            else                state_d = S_IDLE;
          end
        end else if (redirect) begin
          discard_d = 1'b1;
        end
      end
      S_SLEEP: begin
        if (redirect) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: bus request from state, downstream view from the FIFO head.
  always_comb begin
    o_ireq        = (state_q == S_REQ);
    o_iaddr       = fetch_pc_q;
    o_valid       = !fifo_empty;
    o_instruction = head_entry.instr;
    o_pc          = head_entry.pc;
    o_instr_abort = head_entry.abort;
  end

  zap_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .push_i  (fifo_push),
    .data_i  (push_entry),
    .pop_i   (fifo_pop),
    .flush_i (redirect),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .data_o  (head_entry)
  );

endmodule
